// File: rtl/jk_reg_bank_if.sv
// Control and status bundle for jk_reg_bank: operation inputs plus the
// registered state and accounting outputs.
interface jk_reg_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic             clr_cnt;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] chg_mask;
    logic             q_changed;
    logic [CNT_W-1:0] flip_cnt;
    logic             sr_err;

    modport master (
        output en, mode, load, load_data, J, K, clr_cnt,
        input  Q, chg_mask, q_changed, flip_cnt, sr_err
    );

    modport slave (
        input  en, mode, load, load_data, J, K, clr_cnt,
        output Q, chg_mask, q_changed, flip_cnt, sr_err
    );
endinterface

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH flops switchable at runtime between JK, T, D and SR behaviour,
// with parallel load, per-edge change mask and a saturating flip counter.
module jk_reg_bank #(
    parameter int               WIDTH   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    jk_reg_bank_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_JK = 2'd0,
        MODE_T  = 2'd1,
        MODE_D  = 2'd2,
        MODE_SR = 2'd3
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] op_next;
    logic [WIDTH-1:0] op_diff;
    logic [CNT_W:0]   flips;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_sat;
    logic             op_cycle;
    logic             sr_illegal;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        op_next = q_q;
        unique case (mode_e'(bus.mode))
            MODE_JK: op_next = (bus.J & ~q_q) | (~bus.K & q_q);
            MODE_T:  op_next = q_q ^ bus.J;
            MODE_D:  op_next = bus.J;
            MODE_SR: op_next = (bus.J & ~bus.K) | (q_q & ~(bus.J ^ bus.K));
        endcase
    end

    assign op_cycle   = bus.en && !bus.load;
    assign op_diff    = q_q ^ op_next;
    assign sr_illegal = op_cycle && (mode_e'(bus.mode) == MODE_SR) && |(bus.J & bus.K);

    // Popcount and sum carry one spare bit so the clamp sees the overflow.
    always_comb begin
        flips = '0;
        for (int i = 0; i < WIDTH; i++) begin
            flips = flips + {{CNT_W{1'b0}}, op_diff[i]};
        end
    end

    assign cnt_sum = {1'b0, cnt_q} + flips;
    assign cnt_sat = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    always_comb begin
        q_d   = q_q;
        chg_d = '0;
        cnt_d = cnt_q;
        if (bus.load) begin
            q_d   = bus.load_data;
            chg_d = q_q ^ bus.load_data;
        end else if (bus.en) begin
            q_d   = op_next;
            chg_d = op_diff;
            cnt_d = cnt_sat;
        end
        if (bus.clr_cnt) begin
            cnt_d = '0;
        end
        // A fresh illegal SR event outranks a same-cycle clear.
        err_d = sr_illegal || (err_q && !bus.clr_cnt);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= RST_VAL;
            chg_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.Q         = q_q;
    assign bus.chg_mask  = chg_q;
    assign bus.q_changed = |chg_q;
    assign bus.flip_cnt  = cnt_q;
    assign bus.sr_err    = err_q;
endmodule

// File: doc/jk_reg_bank.md
Name: jk_reg_bank

Overview:
- Parametrised, multi-mode register bank of WIDTH independent flip-flop bits. Each bit takes per-bit J/K inputs.
- Runtime mode select makes every bit behave as JK, T, D or SR (with illegal-input detection).
- Adds synchronous parallel load, global enable, a per-bit change mask and a saturating flip counter.
- Used wherever the design needs a bank of control/status flops with toggle accounting, e.g. status registers and test-pattern state.

Parameters:
- WIDTH, 8, number of flop bits (1..32)
- CNT_W, 8, width of saturating flip counter (>= ceil(log2(WIDTH+1)))
- RST_VAL, 0 (WIDTH bits), value loaded into Q on reset

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  global enable for J/K/mode operation
- mode  input  2  0=JK, 1=T, 2=D, 3=SR
- load  input  1  synchronous parallel load strobe
- load_data  input  WIDTH  value written to Q on load
- J  input  WIDTH  per-bit J (T input in mode 1, D input in mode 2, S in mode 3)
- K  input  WIDTH  per-bit K (ignored in modes 1, 2; R in mode 3)
- clr_cnt  input  1  synchronous clear of flip_cnt and sr_err
- Q  output  WIDTH  register state
- chg_mask  output  WIDTH  bits of Q that changed at the last edge
- q_changed  output  1  OR-reduction of chg_mask
- flip_cnt  output  CNT_W  saturating count of bit flips caused by en operations
- sr_err  output  1  sticky flag: SR mode saw S=R=1 on some bit

Behaviour:
- Single clock; reset is synchronous and active-high. Port names clk and rst.
- Reset (rst=1 at edge): Q=RST_VAL, chg_mask=0, q_changed=0, flip_cnt=0, sr_err=0. rst overrides all other inputs. Reset mid-operation discards any pending load or operation that cycle.
- Priority per edge: rst > load > en > hold.
- load=1: Q<=load_data, regardless of en, mode, J and K.
  - chg_mask reflects the load's changes: Q_old ^ load_data.
  - Load flips are NOT added to flip_cnt.
  - sr_err is not set during a load cycle.
- en=1, load=0: each bit i computes next as follows.
  - JK: {J,K}=00 hold, 01 clear, 10 set, 11 toggle.
  - T: J=1 toggle, J=0 hold.
  - D: next=J.
  - SR: 10 set, 01 clear, 00 hold, 11 illegal → bit holds, sr_err<=1.
- en=0, load=0: Q holds; chg_mask<=0.
- chg_mask is registered with Q: it equals Q_prev ^ Q_new for the edge just taken, so it is visible the same cycle the new Q is visible.
- q_changed = |chg_mask. Combinational from the chg_mask register, so no added latency.
- flip_cnt, on en operation cycles:
  - flip_cnt <= min(flip_cnt + popcount(Q_prev ^ Q_next), 2^CNT_W − 1).
  - Saturates at all-ones and never wraps.
  - Sum is computed at CNT_W+1 bits before the clamp.
- clr_cnt=1: flip_cnt<=0 and sr_err<=0.
  - If a flip or SR illegal event occurs in the same cycle, clear wins for flip_cnt (result 0).
  - The new error wins for sr_err (result 1).
- mode changes take effect on the same edge; no state carries between modes other than Q.
- All outputs are registered except q_changed. No combinational path from inputs to outputs.

Test Plan:
- Reset: WIDTH=8, RST_VAL=8'hA5; assert rst 2 cycles with load=1 and en=1 → Q=A5, chg_mask=00, flip_cnt=0, sr_err=0.
- JK mode: Q=00, en=1, J=F0, K=0F → Q=F0, chg_mask=F0, flip_cnt=4.
  - Next cycle J=FF, K=FF → Q=0F, chg_mask=FF, flip_cnt=12.
- Load priority: Q=0F, load=1, load_data=3C, en=1, mode=T, J=FF → Q=3C, chg_mask=33, flip_cnt unchanged.
- SR illegal: mode=3, Q=00, J=81, K=01 → Q=80; sr_err=1 next cycle and stays 1.
  - clr_cnt with SR legal inputs → sr_err=0, flip_cnt=0.
- Saturation: CNT_W=4, mode=T, J=FF for 2 cycles (8+8 flips) → flip_cnt=15, then stays 15 while toggling.
  - clr_cnt with toggle in the same cycle → flip_cnt=0.
- Hold/D: en=0, mode=D, J=55 → Q unchanged, q_changed=0.
  - en=1 → Q=55, q_changed=1.
  - Same J next cycle → chg_mask=00, q_changed=0.
